// File: rtl/servo_pwm_pkg.sv
// Shared constants for the servo PWM array: FP16 field layout, angle range and
// default frame timing at 50 MHz.
package servo_pwm_pkg;

  localparam int FP_EXP_W  = 5;
  localparam int FP_MANT_W = 10;
  localparam int EXP_BIAS  = 15;
  localparam int MAX_DEG   = 180;
  localparam int DEG_W     = 8;

  // Above this exponent the integer part of the value is already >= 256.
  localparam int SAT_EXP   = EXP_BIAS + FP_MANT_W - 3;

  localparam int DEF_PERIOD_TICKS  = 1_000_000;
  localparam int DEF_PULSE_MIN     = 25_000;
  localparam int DEF_PULSE_MAX     = 125_000;
  localparam int DEF_TICKS_PER_DEG = 556;
  localparam int DEF_SLEW_TICKS    = 0;
  localparam int DEF_RESET_TICKS   = 75_040;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp16_t;

endpackage

// File: rtl/fp16_to_deg.sv
// Combinational FP16 -> integer degrees (truncating, saturating at MAX_DEG).
// NaN and infinities raise invalid; negatives and values below 1.0 give 0.
module fp16_to_deg
  import servo_pwm_pkg::*;
(
  input  logic [15:0]      angle,
  output logic [DEG_W-1:0] deg,
  output logic             invalid
);

  fp16_t                f;
  logic [FP_MANT_W:0]   sig;
  logic [FP_MANT_W:0]   shifted;

  assign f   = fp16_t'(angle);
  assign sig = {1'b1, f.mant};

  always_comb begin
    deg     = '0;
    invalid = 1'b0;
    shifted = '0;
    if (f.exp == '1) begin
      invalid = 1'b1;
    end else if (f.sign || (f.exp < FP_EXP_W'(EXP_BIAS))) begin
      deg = '0;
    end else if (f.exp > FP_EXP_W'(SAT_EXP)) begin
      deg = DEG_W'(MAX_DEG);
    end else begin
      // Exponent range here leaves a right shift of 3..10 on the 11-bit significand.
      shifted = sig >> (FP_EXP_W'(EXP_BIAS + FP_MANT_W) - f.exp);
      deg     = (shifted > (FP_MANT_W+1)'(MAX_DEG)) ? DEG_W'(MAX_DEG) : shifted[DEG_W-1:0];
    end
  end

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: shared frame counter, FP16 angle commands,
// frame-boundary commit of new widths with optional per-frame slew limit.
module servo_pwm_array
  import servo_pwm_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int PERIOD_TICKS  = DEF_PERIOD_TICKS,
  parameter int PULSE_MIN     = DEF_PULSE_MIN,
  parameter int PULSE_MAX     = DEF_PULSE_MAX,
  parameter int TICKS_PER_DEG = DEF_TICKS_PER_DEG,
  parameter int SLEW_TICKS    = DEF_SLEW_TICKS,
  parameter int RESET_TICKS   = DEF_RESET_TICKS,
  localparam int CHW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CHW-1:0]  cmd_ch,
  input  logic [15:0]     cmd_angle,
  output logic            cmd_err,
  output logic [N_CH-1:0] pwm_out,
  output logic            frame_start,
  output logic [N_CH-1:0] at_target
);

  localparam int CW = $clog2(PERIOD_TICKS);
  localparam int TW = $clog2(((PERIOD_TICKS > PULSE_MAX) ? PERIOD_TICKS : PULSE_MAX) + 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             wrap;
  logic             en_latch;
  logic             accept;
  logic             ch_bad;

  logic [DEG_W-1:0] conv_deg;
  logic             conv_inv;

  logic             s_vld;
  logic             s_bad;
  logic [CHW-1:0]   s_ch;
  logic [DEG_W-1:0] s_deg;
  logic [TW-1:0]    s_ticks;
  int               ticks_i;

  logic [TW-1:0]    active     [N_CH];
  logic [TW-1:0]    target     [N_CH];
  logic [TW-1:0]    active_nxt [N_CH];

  assign wrap    = (cnt == CW'(PERIOD_TICKS - 1));
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
  assign accept  = cmd_valid & cmd_ready;
  assign ch_bad  = (int'(cmd_ch) >= N_CH);
  assign cmd_err = s_vld & s_bad;

  fp16_to_deg u_conv (
    .angle   (cmd_angle),
    .deg     (conv_deg),
    .invalid (conv_inv)
  );

  // Ready is registered from cnt_nxt so it lines up with cnt; it drops for the
  // last two cycles so a command can still land before the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      frame_start <= 1'b0;
      en_latch    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      cmd_ready   <= (cnt_nxt < CW'(PERIOD_TICKS - 2));
      frame_start <= (cnt_nxt == '0);
      if (wrap) en_latch <= enable;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_vld <= 1'b0;
      s_bad <= 1'b0;
      s_ch  <= '0;
      s_deg <= '0;
    end else begin
      s_vld <= accept;
      if (accept) begin
        s_ch  <= cmd_ch;
        s_deg <= conv_deg;
        s_bad <= conv_inv | ch_bad;
      end
    end
  end

  always_comb begin
    ticks_i = PULSE_MIN + int'(s_deg) * TICKS_PER_DEG;
    if (ticks_i > PULSE_MAX) ticks_i = PULSE_MAX;
    s_ticks = TW'(ticks_i);
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      active_nxt[i] = target[i];
      if (SLEW_TICKS != 0) begin
        if ((target[i] > active[i]) && ((target[i] - active[i]) > TW'(SLEW_TICKS)))
          active_nxt[i] = active[i] + TW'(SLEW_TICKS);
        else if ((active[i] > target[i]) && ((active[i] - target[i]) > TW'(SLEW_TICKS)))
          active_nxt[i] = active[i] - TW'(SLEW_TICKS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= TW'(RESET_TICKS);
        target[i] <= TW'(RESET_TICKS);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s_vld && !s_bad && (s_ch == CHW'(i))) target[i] <= s_ticks;
        if (wrap) active[i] <= active_nxt[i];
      end
    end
  end

  // Registered compare: the pulse trails cnt by one cycle and is exactly active[i] wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        pwm_out[i] <= en_latch & (TW'(cnt) < active[i]);
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < N_CH; i++)
      at_target[i] = (active[i] == target[i]);
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array using a shortened frame: table of angle commands
// with expected per-channel widths, plus hand-written frame-boundary sequences.
module tb_servo_pwm_array;

  localparam int P = 1500;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_valid2 = 1'b0;
  logic [1:0]    cmd_ch = '0;
  logic [0:0]    cmd_ch2 = '0;
  logic [15:0]   cmd_angle = '0;

  logic          cmd_ready, cmd_err, frame_start;
  logic [N-1:0]  pwm_out, at_target;
  logic          cmd_ready2, cmd_err2, frame_start2;
  logic [0:0]    pwm2, at2;

  int total = 0;
  int bad = 0;
  int w[N];
  int w2;

  always #5 clk = ~clk;

  servo_pwm_array #(
    .N_CH(N), .PERIOD_TICKS(P), .PULSE_MIN(100), .PULSE_MAX(950),
    .TICKS_PER_DEG(5), .SLEW_TICKS(0), .RESET_TICKS(550)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_angle(cmd_angle), .cmd_err(cmd_err), .pwm_out(pwm_out),
    .frame_start(frame_start), .at_target(at_target)
  );

  servo_pwm_array #(
    .N_CH(1), .PERIOD_TICKS(P), .PULSE_MIN(100), .PULSE_MAX(950),
    .TICKS_PER_DEG(5), .SLEW_TICKS(90), .RESET_TICKS(550)
  ) dut_slew (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_ch(cmd_ch2),
    .cmd_angle(cmd_angle), .cmd_err(cmd_err2), .pwm_out(pwm2),
    .frame_start(frame_start2), .at_target(at2)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] ang;
    bit          err;
    int          w0, w1, w2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    int k;
    @(negedge clk);
    k = 0;
    while (!frame_start && k < P + 5) begin
      @(negedge clk);
      k++;
    end
    check("frame_start seen", int'(frame_start), 1);
  endtask

  // Counts high cycles over one whole frame, starting at the frame_start cycle.
  task automatic measure(input int drop_at);
    wait_frame();
    for (int c = 0; c < N; c++) w[c] = 0;
    w2 = 0;
    for (int i = 0; i < P; i++) begin
      if (i == drop_at) enable = 1'b0;
      for (int c = 0; c < N; c++) if (pwm_out[c]) w[c]++;
      if (pwm2[0]) w2++;
      if (i != P - 1) @(negedge clk);
    end
  endtask

  task automatic send(input bit to2, input logic [1:0] ch, input logic [15:0] ang,
                      output bit err);
    int k;
    @(negedge clk);
    cmd_ch    = ch;
    cmd_angle = ang;
    if (to2) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    k = 0;
    while (!(to2 ? cmd_ready2 : cmd_ready) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready wait", int'(to2 ? cmd_ready2 : cmd_ready), 1);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
    err = to2 ? cmd_err2 : cmd_err;
  endtask

  initial begin
    bit e;
    int k;
    int cnt_hi;
    int slew_exp[5];

    slew_exp = '{640, 730, 820, 910, 950};
    vecs[0] = '{2'd0, 16'h5060, 1'b0, 275, 550, 550};
    vecs[1] = '{2'd1, 16'h59A0, 1'b0, 275, 950, 550};
    vecs[2] = '{2'd2, 16'h7E00, 1'b1, 275, 950, 550};
    vecs[3] = '{2'd2, 16'hC000, 1'b0, 275, 950, 100};
    vecs[4] = '{2'd3, 16'h5060, 1'b1, 275, 950, 100};
    vecs[5] = '{2'd0, 16'h3C00, 1'b0, 105, 950, 100};
    vecs[6] = '{2'd1, 16'h7C00, 1'b1, 105, 950, 100};
    vecs[7] = '{2'd1, 16'h0001, 1'b0, 105, 100, 100};
    vecs[8] = '{2'd0, 16'h5A00, 1'b0, 950, 100, 100};
    vecs[9] = '{2'd2, 16'h4D00, 1'b0, 950, 100, 200};

    #1;
    check("rst pwm_out", int'(pwm_out), 0);
    check("rst cmd_ready", int'(cmd_ready), 0);
    check("rst cmd_err", int'(cmd_err), 0);
    check("rst frame_start", int'(frame_start), 0);
    check("rst at_target", int'(at_target), 7);
    check("rst slew at_target", int'(at2), 1);
    repeat (3) @(negedge clk);
    check("rst held pwm_out", int'(pwm_out), 0);
    enable = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    check("ready after reset", int'(cmd_ready), 1);
    check("no pwm before latch", int'(pwm_out), 0);

    // Slew-limited ramp from 550 toward the clamped 950.
    send(1'b1, 2'd0, 16'h59A0, e);
    check("slew cmd err", int'(e), 0);
    for (int f = 0; f < 5; f++) begin
      measure(-1);
      check($sformatf("slew width f%0d", f), w2, slew_exp[f]);
      check($sformatf("slew at_target f%0d", f), int'(at2), (f == 4) ? 1 : 0);
      if (f == 0)
        for (int c = 0; c < N; c++) check($sformatf("reset width ch%0d", c), w[c], 550);
    end

    wait_frame();
    k = 1;
    @(negedge clk);
    while (!frame_start && k < P + 5) begin
      @(negedge clk);
      k++;
    end
    check("frame period", k, P);

    for (int v = 0; v < 10; v++) begin
      send(1'b0, vecs[v].ch, vecs[v].ang, e);
      check($sformatf("v%0d cmd_err", v), int'(e), int'(vecs[v].err));
      @(negedge clk);
      check($sformatf("v%0d cmd_err pulse end", v), int'(cmd_err), 0);
      measure(-1);
      check($sformatf("v%0d width ch0", v), w[0], vecs[v].w0);
      check($sformatf("v%0d width ch1", v), w[1], vecs[v].w1);
      check($sformatf("v%0d width ch2", v), w[2], vecs[v].w2);
      check($sformatf("v%0d at_target", v), int'(at_target), 7);
    end

    // Command presented at cnt = P-2: held off two cycles, applies the frame after.
    wait_frame();
    repeat (P - 2) @(negedge clk);
    check("late ready at P-2", int'(cmd_ready), 0);
    cmd_ch = 2'd0; cmd_angle = 16'h5060; cmd_valid = 1'b1;
    @(negedge clk);
    check("late ready at P-1", int'(cmd_ready), 0);
    @(negedge clk);
    check("late ready at 0", int'(cmd_ready), 1);
    check("late frame_start", int'(frame_start), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt_hi = 0;
    for (int i = 0; i < P - 1; i++) begin
      if (pwm_out[0]) cnt_hi++;
      if (i != P - 2) @(negedge clk);
    end
    check("late current frame ch0", cnt_hi, 950);
    measure(-1);
    check("late next frame ch0", w[0], 275);

    // Enable dropped mid-pulse: this frame completes, the next is silent.
    measure(100);
    check("en drop ch0", w[0], 275);
    check("en drop ch1", w[1], 100);
    check("en drop ch2", w[2], 200);
    measure(-1);
    check("disabled ch0", w[0], 0);
    check("disabled ch2", w[2], 0);
    enable = 1'b1;

    // Asynchronous reset in the middle of a pulse.
    wait_frame();
    repeat (20) @(negedge clk);
    check("pre-reset pwm ch0", int'(pwm_out[0]), 1);
    reset = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset slew pwm", int'(pwm2), 0);
    check("async reset ready", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset pwm idle", int'(pwm_out), 0);
    measure(-1);
    for (int c = 0; c < N; c++) check($sformatf("post-reset width ch%0d", c), w[c], 550);
    check("post-reset slew width", w2, 550);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
